// File: rtl/maxnet_pair_sequencer.sv
// maxnet_pair_sequencer
//
// Streams the (weight, activation) pairs for every MaxNet neuron net input to a
// downstream MAC in row-major N x N order. The symmetric weight matrix is stored as its
// upper triangle (w00,w01,..,w0N-1,w11,..,wN-1N-1), so lower-triangle pairs reuse the
// mirrored entry. Weights and activations are snapshotted when a sweep starts, so the
// stream does not change if the upstream buffers do.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        begin one sweep (only honoured while idle)
//   weights_flat WCOUNT triangular weights, entry k at [DW*k +: DW]
//   act_flat     N activations, entry j at [DW*j +: DW]
//   w_out        weight of the presented pair
//   a_out        activation of the presented pair
//   row_idx      neuron i the presented pair belongs to
//   last_in_row  presented pair is the final one of its row (j == N-1)
//   pair_valid   a pair is presented
//   pair_ready   downstream accepts the presented pair
//   busy         a sweep is in progress (streaming or signalling done)
//   done         one-cycle pulse after the final pair has transferred
module maxnet_pair_sequencer #(
  parameter int N      = 4,
  parameter int DW     = 32,
  parameter int WCOUNT = N * (N + 1) / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WCOUNT*DW-1:0] weights_flat,
  input  logic [N*DW-1:0]      act_flat,
  output logic [DW-1:0]        w_out,
  output logic [DW-1:0]        a_out,
  output logic [$clog2(N)-1:0] row_idx,
  output logic                 last_in_row,
  output logic                 pair_valid,
  input  logic                 pair_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = $clog2(N);
  localparam int KW = $clog2(WCOUNT);
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [IW-1:0]   j_q, j_d;
  logic            capture;
  logic [DW-1:0]   w_snap_q [WCOUNT];
  logic [DW-1:0]   a_snap_q [N];

  int              tri_r;
  int              tri_c;
  int              tri_k;
  logic [KW-1:0]   widx;

  // State, indices and snapshots.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      for (int k = 0; k < WCOUNT; k++) w_snap_q[k] <= '0;
      for (int k = 0; k < N; k++) a_snap_q[k] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      if (capture) begin
        for (int k = 0; k < WCOUNT; k++) w_snap_q[k] <= weights_flat[DW*k +: DW];
        for (int k = 0; k < N; k++) a_snap_q[k] <= act_flat[DW*k +: DW];
      end
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    capture    = 1'b0;
    pair_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          capture = 1'b1;
          i_d     = '0;
          j_d     = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        busy       = 1'b1;
        pair_valid = 1'b1;
        if (pair_ready) begin
          if (j_q != LastIdx) begin
            j_d = j_q + 1'b1;
          end else if (i_q != LastIdx) begin
            j_d = '0;
            i_d = i_q + 1'b1;
          end else begin
            // Final pair accepted; park the indices at the origin.
            i_d     = '0;
            j_d     = '0;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Triangular index: fold (i,j) onto the upper triangle, then offset into row r.
  always_comb begin
    tri_r = (i_q < j_q) ? int'(i_q) : int'(j_q);
    tri_c = (i_q < j_q) ? int'(j_q) : int'(i_q);
    tri_k = tri_r * N - (tri_r * (tri_r - 1)) / 2 + (tri_c - tri_r);
    widx  = KW'(tri_k);
  end

  // Data outputs come from registers only and read zero outside of streaming.
  always_comb begin
    w_out       = '0;
    a_out       = '0;
    row_idx     = '0;
    last_in_row = 1'b0;
    if (state_q == StStream) begin
      w_out       = w_snap_q[widx];
      a_out       = a_snap_q[j_q];
      row_idx     = i_q;
      last_in_row = (j_q == LastIdx);
    end
  end

endmodule

// File: tb/tb_maxnet_pair_sequencer.sv
module tb_maxnet_pair_sequencer;

  localparam int N      = 4;
  localparam int DW     = 32;
  localparam int WCOUNT = N * (N + 1) / 2;
  localparam int NN     = N * N;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [WCOUNT*DW-1:0] weights_flat;
  logic [N*DW-1:0]      act_flat;
  logic [DW-1:0]        w_out;
  logic [DW-1:0]        a_out;
  logic [$clog2(N)-1:0] row_idx;
  logic                 last_in_row;
  logic                 pair_valid;
  logic                 pair_ready;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;

  // Stimulus values and the model's captured copy.
  logic [DW-1:0] tw [WCOUNT];
  logic [DW-1:0] ta [N];
  logic [DW-1:0] mw [WCOUNT];
  logic [DW-1:0] ma [N];

  maxnet_pair_sequencer #(
    .N      (N),
    .DW     (DW),
    .WCOUNT (WCOUNT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .weights_flat (weights_flat),
    .act_flat     (act_flat),
    .w_out        (w_out),
    .a_out        (a_out),
    .row_idx      (row_idx),
    .last_in_row  (last_in_row),
    .pair_valid   (pair_valid),
    .pair_ready   (pair_ready),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_inputs();
    for (int k = 0; k < WCOUNT; k++) weights_flat[DW*k +: DW] = tw[k];
    for (int k = 0; k < N; k++) act_flat[DW*k +: DW] = ta[k];
  endtask

  task automatic latch_model();
    for (int k = 0; k < WCOUNT; k++) mw[k] = tw[k];
    for (int k = 0; k < N; k++) ma[k] = ta[k];
  endtask

  task automatic rand_data();
    for (int k = 0; k < WCOUNT; k++) tw[k] = $urandom;
    for (int k = 0; k < N; k++) ta[k] = $urandom;
  endtask

  // Symmetric matrix element: walk the stored upper triangle and match either orientation.
  function automatic logic [DW-1:0] exp_w(int i, int j);
    int k;
    k     = 0;
    exp_w = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = r; c < N; c++) begin
        if ((r == i && c == j) || (r == j && c == i)) exp_w = mw[k];
        k++;
      end
    end
  endfunction

  task automatic test_reset();
    rand_data();
    load_inputs();
    rst        = 1'b0;
    pair_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst   = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 2; c++) begin
      weights_flat = {WCOUNT{$urandom}};
      act_flat     = {N{$urandom}};
      pair_ready   = 1'(c);
      tick();
      checks++;
      if (pair_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset pair_valid got %b exp 0", pair_valid);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL reset busy got %b exp 0", busy);
      end
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL reset done got %b exp 0", done);
      end
      checks++;
      if ({w_out, a_out, row_idx, last_in_row} !== '0) begin
        errors++;
        $display("FAIL reset data w=%h a=%h row=%0d last=%b exp all 0",
                 w_out, a_out, row_idx, last_in_row);
      end
    end
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || pair_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored busy=%b valid=%b exp 0 0", busy, pair_valid);
    end
  endtask

  task automatic test_full_sweep();
    int k, np, done_cyc, done_cnt, busy_cnt, i, j;
    k = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = r; c < N; c++) begin
        tw[k] = (r == c) ? 32'h3F80_0000 : 32'hBE4C_CCCD;
        k++;
      end
    end
    ta[0] = 32'h3F00_0000;
    ta[1] = 32'h3F40_0000;
    ta[2] = 32'h3E80_0000;
    ta[3] = 32'h3F80_0000;
    load_inputs();
    latch_model();
    pair_ready = 1'b1;
    start      = 1'b1;
    tick();
    start    = 1'b0;
    np       = 0;
    done_cyc = 0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pair_valid) begin
        i = np / N;
        j = np % N;
        checks++;
        if (np >= NN) begin
          errors++;
          $display("FAIL full extra_pair got pair %0d exp at most %0d", np, NN);
        end else begin
          if (w_out !== exp_w(i, j)) begin
            errors++;
            $display("FAIL full w_out pair %0d got %h exp %h", np, w_out, exp_w(i, j));
          end
          checks++;
          if (a_out !== ma[j]) begin
            errors++;
            $display("FAIL full a_out pair %0d got %h exp %h", np, a_out, ma[j]);
          end
          checks++;
          if (int'(row_idx) !== i) begin
            errors++;
            $display("FAIL full row_idx pair %0d got %0d exp %0d", np, row_idx, i);
          end
          checks++;
          if (last_in_row !== (j == N - 1)) begin
            errors++;
            $display("FAIL full last_in_row pair %0d got %b exp %b", np, last_in_row, j == N - 1);
          end
          if (np == 0 || np == 1 || np == 5) begin
            checks++;
            if ((np == 0 && {w_out, a_out, row_idx} !== {32'h3F80_0000, 32'h3F00_0000, 2'd0}) ||
                (np == 1 && {w_out, a_out} !== {32'hBE4C_CCCD, 32'h3F40_0000}) ||
                (np == 5 && {w_out, a_out, row_idx} !== {32'h3F80_0000, 32'h3F40_0000, 2'd1}))
            begin
              errors++;
              $display("FAIL full known_pair %0d got w=%h a=%h row=%0d", np, w_out, a_out, row_idx);
            end
          end
        end
        np++;
      end
      tick();
    end
    checks++;
    if (np !== NN) begin
      errors++;
      $display("FAIL full pair_count got %0d exp %0d", np, NN);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 17) begin
      errors++;
      $display("FAIL full done got count %0d cycle %0d exp count 1 cycle 17", done_cnt, done_cyc);
    end
    checks++;
    if (busy_cnt !== 17) begin
      errors++;
      $display("FAIL full busy_cycles got %0d exp 17", busy_cnt);
    end
  endtask

  task automatic test_symmetric();
    int np, expc;
    for (int k = 0; k < WCOUNT; k++) tw[k] = k;
    for (int k = 0; k < N; k++) ta[k] = 32'h100 + k;
    load_inputs();
    latch_model();
    pair_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    np    = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (pair_valid && np < NN) begin
        checks++;
        if (w_out !== exp_w(np / N, np % N)) begin
          errors++;
          $display("FAIL sym w_out pair (%0d,%0d) got %h exp %h",
                   np / N, np % N, w_out, exp_w(np / N, np % N));
        end
        case (np)
          4:       expc = 1;
          9:       expc = 5;
          12:      expc = 3;
          14:      expc = 8;
          15:      expc = 9;
          10:      expc = 7;
          default: expc = -1;
        endcase
        if (expc >= 0) begin
          checks++;
          if (w_out !== 32'(expc)) begin
            errors++;
            $display("FAIL sym known (%0d,%0d) got %h exp %0d", np / N, np % N, w_out, expc);
          end
        end
        np++;
      end
      tick();
    end
    checks++;
    if (np !== NN) begin
      errors++;
      $display("FAIL sym pair_count got %0d exp %0d", np, NN);
    end
  endtask

  task automatic test_backpressure();
    int np, stall, done_cyc, done_cnt;
    rand_data();
    load_inputs();
    latch_model();
    pair_ready = 1'b1;
    start      = 1'b1;
    tick();
    start    = 1'b0;
    np       = 0;
    stall    = 0;
    done_cyc = 0;
    done_cnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      pair_ready = 1'b1;
      if (pair_valid && np < NN) begin
        checks++;
        if (w_out !== exp_w(np / N, np % N) || a_out !== ma[np % N] ||
            int'(row_idx) !== np / N) begin
          errors++;
          $display("FAIL bp pair %0d stall %0d got w=%h a=%h row=%0d exp w=%h a=%h row=%0d",
                   np, stall, w_out, a_out, row_idx, exp_w(np / N, np % N), ma[np % N], np / N);
        end
        if (np == 6 && stall < 3) begin
          pair_ready = 1'b0;
          stall++;
        end else begin
          np++;
        end
      end
      tick();
    end
    pair_ready = 1'b1;
    checks++;
    if (np !== NN) begin
      errors++;
      $display("FAIL bp pair_count got %0d exp %0d", np, NN);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 20) begin
      errors++;
      $display("FAIL bp done got count %0d cycle %0d exp count 1 cycle 20", done_cnt, done_cyc);
    end
  endtask

  task automatic test_snapshot();
    int np, done_cyc, done_cnt, busy_cnt;
    bit flipped;
    rand_data();
    load_inputs();
    latch_model();
    pair_ready = 1'b1;
    start      = 1'b1;
    tick();
    start    = 1'b0;
    np       = 0;
    done_cyc = 0;
    done_cnt = 0;
    busy_cnt = 0;
    flipped  = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pair_valid && np < NN) begin
        if (np == 5 && !flipped) begin
          weights_flat = ~weights_flat;
          act_flat     = ~act_flat;
          start        = 1'b1;
          flipped      = 1'b1;
        end
        checks++;
        if (w_out !== exp_w(np / N, np % N) || a_out !== ma[np % N]) begin
          errors++;
          $display("FAIL snap pair %0d got w=%h a=%h exp w=%h a=%h",
                   np, w_out, a_out, exp_w(np / N, np % N), ma[np % N]);
        end
        np++;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (np !== NN) begin
      errors++;
      $display("FAIL snap pair_count got %0d exp %0d", np, NN);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 17 || busy_cnt !== 17) begin
      errors++;
      $display("FAIL snap timing got done %0d at %0d busy %0d exp done 1 at 17 busy 17",
               done_cnt, done_cyc, busy_cnt);
    end
  endtask

  task automatic test_random_ready();
    int np, stalls, done_cyc, done_cnt;
    for (int s = 0; s < 4; s++) begin
      rand_data();
      load_inputs();
      latch_model();
      pair_ready = 1'b1;
      start      = 1'b1;
      tick();
      start    = 1'b0;
      np       = 0;
      stalls   = 0;
      done_cyc = 0;
      done_cnt = 0;
      for (int cyc = 1; cyc <= 120; cyc++) begin
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        // Scramble the inputs every cycle; the snapshot must hide it.
        weights_flat = {WCOUNT{$urandom}};
        act_flat     = {N{$urandom}};
        pair_ready   = ($urandom_range(0, 2) != 0);
        if (pair_valid && np < NN) begin
          checks++;
          if (w_out !== exp_w(np / N, np % N) || a_out !== ma[np % N] ||
              int'(row_idx) !== np / N || last_in_row !== (np % N == N - 1)) begin
            errors++;
            $display("FAIL rand sweep %0d pair %0d got w=%h a=%h row=%0d last=%b", s, np,
                     w_out, a_out, row_idx, last_in_row);
          end
          if (pair_ready) np++;
          else stalls++;
        end
        tick();
      end
      checks++;
      if (np !== NN || done_cnt !== 1 || done_cyc !== 17 + stalls) begin
        errors++;
        $display("FAIL rand sweep %0d got pairs %0d done %0d at %0d exp 16 1 at %0d",
                 s, np, done_cnt, done_cyc, 17 + stalls);
      end
    end
    pair_ready = 1'b1;
  endtask

  task automatic test_midstream_reset();
    int np, cyc, done_cyc;
    rand_data();
    load_inputs();
    latch_model();
    pair_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    np    = 0;
    cyc   = 0;
    while (!(pair_valid && np == 9) && cyc < 40) begin
      if (pair_valid) np++;
      tick();
      cyc++;
    end
    checks++;
    if (!(pair_valid && np == 9)) begin
      errors++;
      $display("FAIL midrst reach_pair9 got pair %0d valid %b", np, pair_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (pair_valid !== 1'b0 || busy !== 1'b0 || w_out !== '0) begin
      errors++;
      $display("FAIL midrst after_reset got valid %b busy %b w %h exp 0 0 0",
               pair_valid, busy, w_out);
    end
    rand_data();
    load_inputs();
    latch_model();
    start = 1'b1;
    tick();
    start    = 1'b0;
    np       = 0;
    done_cyc = 0;
    for (int c = 1; c <= 25; c++) begin
      if (done) done_cyc = c;
      if (pair_valid && np < NN) begin
        checks++;
        if (w_out !== exp_w(np / N, np % N) || a_out !== ma[np % N] ||
            int'(row_idx) !== np / N) begin
          errors++;
          $display("FAIL midrst restart pair %0d got w=%h a=%h row=%0d exp w=%h a=%h row=%0d",
                   np, w_out, a_out, row_idx, exp_w(np / N, np % N), ma[np % N], np / N);
        end
        np++;
      end
      tick();
    end
    checks++;
    if (np !== NN || done_cyc !== 17) begin
      errors++;
      $display("FAIL midrst restart_sweep got pairs %0d done at %0d exp 16 at 17", np, done_cyc);
    end
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    pair_ready   = 1'b0;
    weights_flat = '0;
    act_flat     = '0;
    tick();
    tick();
    checks++;
    if ({w_out, a_out, row_idx, last_in_row, pair_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL por outputs got w=%h a=%h row=%0d last=%b valid=%b busy=%b done=%b exp 0",
               w_out, a_out, row_idx, last_in_row, pair_valid, busy, done);
    end
    test_reset();
    test_full_sweep();
    test_symmetric();
    test_backpressure();
    test_snapshot();
    test_random_ready();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxnet_pair_sequencer.md
Name: maxnet_pair_sequencer

Overview:
- Consumes the 10-entry upper-triangular weight set (w00,w01,w02,w03,w11,w12,w13,w22,w23,w33; IEEE-754 single) produced by the weight buffer.
- Streams, one per handshake, the (weight, activation) pairs needed to compute each of the N neuron net inputs of the MaxNet layer to the downstream floating-point MAC.
- Expands the symmetric triangular storage into full row-major N x N order.
- Snapshots weights and activations at start, so the stream is immune to upstream changes.

Parameters:
- N, 4, number of neurons / activations.
- DW, 32, data width of one weight or activation (IEEE-754 single).
- WCOUNT, N*(N+1)/2 (10), number of stored triangular weights.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin one sweep; sampled only in IDLE.
- weights_flat  input  WCOUNT*DW  weight k at bits [DW*k+DW-1 : DW*k], k in triangular order above.
- act_flat  input  N*DW  activation a_j at bits [DW*j+DW-1 : DW*j].
- w_out  output  DW  weight of current pair.
- a_out  output  DW  activation of current pair.
- row_idx  output  clog2(N)  neuron i whose net input the pair belongs to.
- last_in_row  output  1  high when the current pair has j == N-1.
- pair_valid  output  1  current pair is presented.
- pair_ready  input  1  downstream accepts the pair.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after the final pair transfers.

Behaviour:
- Reset: one clock and one synchronous, active-high reset (rst); all sequential state is reset on clk. On rst=1 at an edge: state=IDLE, i=j=0, snapshot registers = 0. All outputs then read 0: w_out, a_out, row_idx, last_in_row, pair_valid, busy, done. rst has priority over every other input, including mid-stream.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - pair_valid=0.
  - start=1 at an edge: capture weights_flat and act_flat into snapshot registers, set i=0, j=0, go to STREAM.
- STREAM:
  - pair_valid=1.
  - w_out = snapshot weight at index idx(i,j). a_out = snapshot a_j. row_idx = i. last_in_row = (j==N-1).
  - Transfer occurs at an edge where pair_valid & pair_ready.
  - On transfer, if j<N-1: j++.
  - On transfer, else if i<N-1: j=0, i++.
  - On transfer, else (i=j=N-1): go to DONE.
  - No transfer: i, j and all outputs held stable. pair_valid never drops while in STREAM.
- DONE:
  - done=1, pair_valid=0, busy=1.
  - Unconditionally go to IDLE at the next edge.
- Index mapping (symmetric):
  - Let r=min(i,j), c=max(i,j).
  - idx = r*N - r*(r-1)/2 + (c-r). For N=4 this gives (0,c)->c, (1,c)->3+c, (2,c)->5+c, (3,3)->9.
  - Computed from registered i,j; outputs are a mux of registers only. No combinational path from any input to any output except pair_ready, which affects nothing combinationally.
- Latency (pair_ready held 1):
  - start sampled at edge E0; pair (0,0) presented in the cycle after E0.
  - The N*N=16 transfers occur at edges E1..E16. done=1 in the cycle after E16. Back in IDLE after E17, so busy is high for 17 cycles.
- start while busy (STREAM or DONE): ignored, no effect on the sweep. A start in the same cycle as done is ignored; a new sweep needs start while in IDLE.
- Changes on weights_flat or act_flat after the capture edge do not affect the current sweep.
- Arithmetic: none on data; values pass bit-exact. Counters are clog2(N) bits and never wrap past N-1.

Test Plan:
- Reset: drive rst=1 for 2 cycles mid-operation with arbitrary inputs -> all outputs 0, busy=0; start held 1 during rst has no effect.
- Full sweep, pair_ready=1:
  - Stimulus: weights = 1.0 (0x3F800000) on the diagonal, -0.2 (0xBE4CCCCD) elsewhere; act = 0x3F000000, 0x3F400000, 0x3E800000, 0x3F800000.
  - Required: 16 pairs in row-major order. Pair 0: w=0x3F800000, a=0x3F000000, row 0. Pair 1: w=0xBE4CCCCD, a=0x3F400000. Pair 5: w=0x3F800000, a=0x3F400000, row 1.
  - Required: last_in_row high on pairs 3,7,11,15; done high for exactly 1 cycle, 17 cycles after the start edge.
- Symmetric mapping: weights[k]=k (integer bit patterns 0..9) -> pair (1,0)=1, (2,1)=5, (3,0)=3, (3,2)=8, (3,3)=9, (2,2)=7.
- Backpressure: pair_ready=0 for 3 cycles while pair (1,2) is presented -> w_out=weights[5], a_out=a2, row_idx=1 held stable all 3 cycles; done arrives at cycle 20 instead of 17; no pair duplicated or skipped.
- Snapshot / start-while-busy: flip every weights_flat and act_flat bit and pulse start after pair 4 -> remaining pairs carry the original values; sweep is not restarted; exactly 16 transfers.
- Reset mid-stream: assert rst during pair 9 -> pair_valid=0 and busy=0 the next cycle; a new start then restarts at (0,0) with freshly captured values.
